ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 6, RAM address width.
REQ-002 Parameter DW, default 8, RAM data width.
REQ-003 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  2  per-requester access request; bit i = requester i.
- wr  in  2  per-requester operation; 1 = write, 0 = read.
- addr  in  2*AW  packed addresses: {addr1, addr0}.
- wdata  in  2*DW  packed write data: {wdata1, wdata0}.
- gnt  out  2  one-hot grant pulse, one cycle per access.
- rvalid  out  2  one-hot read-data-valid pulse.
- rdata  out  DW  read data; meaningful only while rvalid is nonzero.
- ram_CS  out  1  RAM chip select.
- ram_WR  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data; valid in the cycle after a read-select cycle.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RDATA; all outputs are registered.
REQ-005 IDLE: if any req bit is 1, the FSM SHALL pick a winner, latch its wr, addr and wdata, and go to ACCESS; otherwise it stays in IDLE.
REQ-006 ACCESS (one cycle): ram_CS=1, ram_WR=latched wr, ram_addr/ram_din=latched values, gnt[winner]=1.
REQ-007 After a write ACCESS, the FSM SHALL go directly to ACCESS if any req is pending (new winner picked), otherwise to IDLE.
REQ-008 After a read ACCESS, the FSM SHALL go to RDATA; in RDATA, ram_CS=0, and on the RDATA exit edge rdata<=ram_dout and rvalid[winner]<=1 for exactly one cycle.
REQ-009 RDATA exit SHALL follow REQ-007 (next ACCESS if req pending, else IDLE); rvalid therefore coincides with the first cycle of the next state.
REQ-010 Latency from the req-sampling edge: gnt and RAM select 1 cycle; read rvalid 3 cycles.
REQ-011 Arbitration SHALL be round-robin: with both req bits set, the requester not granted last wins; a lone requester always wins.
REQ-012 Requesters SHALL hold req, wr, addr and wdata until they see gnt; a req dropped before grant is never served.
REQ-013 The requester's own grant cycle SHALL NOT count as a new request; a requester re-raises or holds req for further accesses, and a request held through gnt is served again.
REQ-014 Outside ACCESS, ram_CS and gnt SHALL be 0; outside its pulse, rvalid SHALL be 0; rdata holds its last value.

Reset
REQ-015 With rst_n=0, state SHALL be IDLE and gnt, rvalid, ram_CS, ram_WR=0; ram_addr, ram_din and rdata SHALL be 0.
REQ-016 With rst_n=0, the round-robin pointer SHALL favour requester 0 on the first tie.
REQ-017 Reset asserted mid-ACCESS or mid-RDATA SHALL immediately deassert ram_CS and abandon the access; no rvalid follows.

Structure
REQ-018 A shared package SHALL hold the state encoding (IDLE/ACCESS/RDATA) and the AW/DW defaults.
REQ-019 The two-way round-robin picker SHALL be a sub-module rr_arb2: inputs req[1:0] and the last-grant pointer; output a one-hot winner.

Verification
REQ-020 Scenario 1: req0 write, addr 0x05, data 0xA5 -> 1 cycle later gnt=01, ram_CS=1, ram_WR=1, ram_addr=0x05, ram_din=0xA5.
REQ-021 Scenario 2: req1 read of addr 0x05 after Scenario 1 -> gnt=10 at +1; rvalid=10 with rdata=0xA5 at +3 (RAM model: en=1).
REQ-022 Scenario 3: both req held continuously, both write -> gnt sequence 01,10,01,10 on consecutive cycles, no idle gap.
REQ-023 Scenario 4: both req reads held -> grants alternate 01 then 10, separated by RDATA; rvalid order 01 then 10; each rdata matches its address.
REQ-024 Scenario 5: rst_n pulsed low during RDATA -> ram_CS=0 and gnt=0 at once; no rvalid afterwards; next tie grants requester 0.
REQ-025 Scenario 6: req0 raised for one cycle, dropped while FSM in RDATA for req1 -> req0 never granted.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: default geometry
// and the controller state encoding.
package ram_arbiter_pkg;

  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 8;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_ACCESS = 2'd1;
  localparam logic [ST_W-1:0] ST_RDATA  = 2'd2;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker.
//   req      : request vector, bit i = requester i
//   last_gnt : index of the requester granted most recently
//   win_c    : one-hot winner (combinational), zero when no request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] win_c
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    win_c = req;
    if (req == 2'b11) begin
      win_c = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one single-port synchronous RAM.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req, wr         : per-requester request and write (1) / read (0)
//   addr, wdata     : packed {requester1, requester0} address / write data
//   gnt             : one-hot grant pulse during the RAM access cycle
//   rvalid, rdata   : one-hot read-valid pulse with the returned data
//   ram_CS, ram_WR  : RAM chip select / write enable
//   ram_addr/ram_din: RAM address / write data
//   ram_dout        : RAM read data, valid the cycle after a read select
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    wr,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_CS,
  output logic          ram_WR,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [ST_W-1:0] state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            cs_q, cs_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [1:0]      win_q, win_d;
  logic            last_q, last_d;

  logic [1:0]      req_eff_c;
  logic [1:0]      pick_c;
  logic            launch_c;

  // The requester being granted this cycle is still holding req; that
  // level belongs to the access in progress, not to a new request.
  always_comb begin
    req_eff_c = req;
    if (state_q == ST_ACCESS) begin
      req_eff_c = req & ~win_q;
    end
  end

  rr_arb2 u_rr_arb2 (
    .req      (req_eff_c),
    .last_gnt (last_q),
    .win_c    (pick_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    cs_d     = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    win_d    = win_q;
    last_d   = last_q;
    launch_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        launch_c = |req_eff_c;
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d  = ST_IDLE;
          launch_c = |req_eff_c;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        state_d  = ST_IDLE;
        rvalid_d = win_q;
        rdata_d  = ram_dout;
        launch_c = |req_eff_c;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Start a new access for the picked requester, latching its command.
    if (launch_c) begin
      state_d = ST_ACCESS;
      gnt_d   = pick_c;
      cs_d    = 1'b1;
      win_d   = pick_c;
      last_d  = pick_c[1];
      we_d    = pick_c[1] ? wr[1] : wr[0];
      addr_d  = pick_c[1] ? addr[2*AW-1:AW] : addr[AW-1:0];
      din_d   = pick_c[1] ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    end
  end

  // State and output registers; the pointer resets to favour requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      win_q    <= 2'b00;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      win_q    <= win_d;
      last_q   <= last_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign ram_CS   = cs_q;
  assign ram_WR   = we_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: expected grants and read returns are
// queued with their cycle numbers as stimulus is applied and compared as
// the DUT produces them.
module tb_ram_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req;
  logic [1:0]    wr;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          ram_CS;
  logic          ram_WR;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  typedef struct {
    int            cyc;
    logic [1:0]    gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } gexp_t;

  typedef struct {
    int            cyc;
    logic [1:0]    rv;
    logic [DW-1:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] mem [2**AW];

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_CS   (ram_CS),
    .ram_WR   (ram_WR),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM: read data appears the cycle after select.
  initial begin
    ram_dout = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    if (ram_CS) begin
      if (ram_WR) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_g(input int c, input logic [1:0] g, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    gexp_t e;
    e.cyc = c; e.gnt = g; e.we = we; e.addr = a; e.din = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input int c, input logic [1:0] rv, input logic [DW-1:0] d);
    rexp_t e;
    e.cyc = c; e.rv = rv; e.data = d;
    rq.push_back(e);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]             = 1'b1;
    wr[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  task automatic drop(input int i);
    req[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every cycle either matches the queue head or is quiet.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (mon_en) begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        chk("gnt_missing_at", 32'(cyc), 32'(gq[0].cyc));
        g = gq.pop_front();
      end
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        g = gq.pop_front();
        chk("gnt",      32'(gnt),      32'(g.gnt));
        chk("ram_CS",   32'(ram_CS),   32'd1);
        chk("ram_WR",   32'(ram_WR),   32'(g.we));
        chk("ram_addr", 32'(ram_addr), 32'(g.addr));
        chk("ram_din",  32'(ram_din),  32'(g.din));
      end else begin
        chk("gnt_idle", 32'(gnt),    32'd0);
        chk("cs_idle",  32'(ram_CS), 32'd0);
      end

      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        chk("rvalid_missing_at", 32'(cyc), 32'(rq[0].cyc));
        r = rq.pop_front();
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        chk("rvalid", 32'(rvalid), 32'(r.rv));
        chk("rdata",  32'(rdata),  32'(r.data));
      end else begin
        chk("rvalid_idle", 32'(rvalid), 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    wr    = '0;
    addr  = '0;
    wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",      32'(gnt),      32'd0);
    chk("rst_rvalid",   32'(rvalid),   32'd0);
    chk("rst_ram_CS",   32'(ram_CS),   32'd0);
    chk("rst_ram_WR",   32'(ram_WR),   32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din",  32'(ram_din),  32'd0);
    chk("rst_rdata",    32'(rdata),    32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Scenario 1: requester 0 writes 0xA5 to 0x05
    set_req(0, 1'b1, 6'h05, 8'hA5);
    push_g(cyc + 1, 2'b01, 1'b1, 6'h05, 8'hA5);
    tick();
    drop(0);
    repeat (2) tick();

    // Scenario 2: requester 1 reads 0x05 back
    set_req(1, 1'b0, 6'h05, 8'h3C);
    push_g(cyc + 1, 2'b10, 1'b0, 6'h05, 8'h3C);
    push_r(cyc + 3, 2'b10, 8'hA5);
    tick();
    drop(1);
    repeat (4) tick();

    // Scenario 3: both writers held, grants alternate back to back
    set_req(0, 1'b1, 6'h10, 8'h11);
    set_req(1, 1'b1, 6'h20, 8'h22);
    push_g(cyc + 1, 2'b01, 1'b1, 6'h10, 8'h11);
    push_g(cyc + 2, 2'b10, 1'b1, 6'h20, 8'h22);
    push_g(cyc + 3, 2'b01, 1'b1, 6'h10, 8'h11);
    push_g(cyc + 4, 2'b10, 1'b1, 6'h20, 8'h22);
    repeat (4) tick();
    drop(0);
    drop(1);
    repeat (3) tick();

    // Scenario 4: both readers held, RDATA separates the grants
    set_req(0, 1'b0, 6'h10, 8'hC0);
    set_req(1, 1'b0, 6'h20, 8'hC1);
    push_g(cyc + 1, 2'b01, 1'b0, 6'h10, 8'hC0);
    push_g(cyc + 3, 2'b10, 1'b0, 6'h20, 8'hC1);
    push_r(cyc + 3, 2'b01, 8'h11);
    push_r(cyc + 5, 2'b10, 8'h22);
    repeat (3) tick();
    drop(0);
    drop(1);
    repeat (5) tick();

    // Scenario 5: reset during RDATA of a requester-0 read
    set_req(0, 1'b0, 6'h20, 8'h77);
    push_g(cyc + 1, 2'b01, 1'b0, 6'h20, 8'h77);
    tick();
    drop(0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_CS",   32'(ram_CS),   32'd0);
    chk("mid_rst_gnt",      32'(gnt),      32'd0);
    chk("mid_rst_rvalid",   32'(rvalid),   32'd0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("mid_rst_rdata",    32'(rdata),    32'd0);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();
    // Tie after reset must go to requester 0
    set_req(0, 1'b1, 6'h31, 8'h5A);
    set_req(1, 1'b1, 6'h32, 8'h6B);
    push_g(cyc + 1, 2'b01, 1'b1, 6'h31, 8'h5A);
    push_g(cyc + 2, 2'b10, 1'b1, 6'h32, 8'h6B);
    repeat (2) tick();
    drop(0);
    drop(1);
    repeat (3) tick();

    // Scenario 6: one-cycle req0 while requester 1's read is in flight
    set_req(1, 1'b0, 6'h10, 8'h00);
    push_g(cyc + 1, 2'b10, 1'b0, 6'h10, 8'h00);
    push_r(cyc + 3, 2'b10, 8'h11);
    tick();
    drop(1);
    set_req(0, 1'b1, 6'h3F, 8'hEE);
    tick();
    drop(0);
    repeat (5) tick();

    chk("gnt_queue_left",    32'(gq.size()), 32'd0);
    chk("rvalid_queue_left", 32'(rq.size()), 32'd0);
    chk("mem_3f_untouched",  32'(mem[6'h3F]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
